// File: rtl/fruit_drop_controller_pkg.sv
// Shared types for the fruit drop controller.
// State enum is also consumed by the collision block.
package fruit_drop_controller_pkg;

  typedef enum logic [1:0] {
    HANGING = 2'd0,
    FALLING = 2'd1,
    POP     = 2'd2,
    GONE    = 2'd3
  } fruitState_t;

  localparam int POINTS_PER_FRUIT = 10;

endpackage

// File: rtl/fruit_drop_controller.sv
// Per-fruit state controller: hang, fall, pop, respawn.
// Drives the single-fruit renderer and reports score pulses.
module fruit_drop_controller
  import fruit_drop_controller_pkg::*;
#(
  parameter logic signed [10:0] HOME_X = 11'sd200,
  parameter logic signed [10:0] HOME_Y = 11'sd64,
  parameter logic signed [10:0] FLOOR_Y = 11'sd416,
  parameter int FALL_STEP = 4,
  parameter int POP_FRAMES = 30,
  parameter int RESPAWN_FRAMES = 120,
  parameter int NUM_FRUITS = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               playerHitFruit,
  input  logic               fruitHitEnemy,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output int                 fruitChoice,
  output logic               drawFruit,
  output logic               scorePulse,
  output logic [7:0]         points
);

  localparam logic signed [11:0] STEP12 = 12'(FALL_STEP);
  localparam logic signed [11:0] FLOOR12 = {FLOOR_Y[10], FLOOR_Y};
  localparam logic [7:0] POP_LAST = 8'(POP_FRAMES - 1);
  localparam logic [7:0] GONE_LAST = 8'(RESPAWN_FRAMES - 1);

  fruitState_t        state;
  fruitState_t        stateNext;
  logic [7:0]         cnt;
  logic [7:0]         cntNext;
  logic signed [10:0] yNext;
  logic signed [11:0] ySum;
  int                 choiceNext;
  logic               drawNext;
  logic               scoreNext;
  logic [7:0]         pointsNext;

  assign ySum = {topLeftY[10], topLeftY} + STEP12;

  // Next-state sequencing; an enemy hit outranks frame motion.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    yNext      = topLeftY;
    choiceNext = fruitChoice;
    scoreNext  = 1'b0;
    pointsNext = points;
    unique case (state)
      HANGING: begin
        if (playerHitFruit) stateNext = FALLING;
      end
      FALLING: begin
        if (fruitHitEnemy) begin
          stateNext  = POP;
          cntNext    = 8'd0;
          scoreNext  = 1'b1;
          pointsNext = 8'(POINTS_PER_FRUIT * (fruitChoice + 1));
        end else if (startOfFrame) begin
          if (ySum >= FLOOR12) begin
            yNext     = FLOOR_Y;
            stateNext = GONE;
            cntNext   = 8'd0;
          end else begin
            yNext = ySum[10:0];
          end
        end
      end
      POP: begin
        if (startOfFrame) begin
          if (cnt == POP_LAST) begin
            stateNext = GONE;
            cntNext   = 8'd0;
          end else begin
            cntNext = cnt + 8'd1;
          end
        end
      end
      GONE: begin
        if (startOfFrame) begin
          if (cnt == GONE_LAST) begin
            stateNext = HANGING;
            cntNext   = 8'd0;
            yNext     = HOME_Y;
            choiceNext = (fruitChoice >= NUM_FRUITS - 1) ?
                         0 : fruitChoice + 1;
          end else begin
            cntNext = cnt + 8'd1;
          end
        end
      end
      default: begin
        stateNext = HANGING;
        cntNext   = 8'd0;
        yNext     = HOME_Y;
      end
    endcase
  end

  // Visibility follows the upcoming state so drawFruit stays registered.
  always_comb begin
    drawNext = 1'b0;
    unique case (stateNext)
      HANGING: drawNext = 1'b1;
      FALLING: drawNext = 1'b1;
      POP:     drawNext = ~cntNext[2];
      GONE:    drawNext = 1'b0;
      default: drawNext = 1'b0;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state       <= HANGING;
      cnt         <= 8'd0;
      topLeftX    <= HOME_X;
      topLeftY    <= HOME_Y;
      fruitChoice <= 0;
      drawFruit   <= 1'b1;
      scorePulse  <= 1'b0;
      points      <= 8'd0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      topLeftX    <= HOME_X;
      topLeftY    <= yNext;
      fruitChoice <= choiceNext;
      drawFruit   <= drawNext;
      scorePulse  <= scoreNext;
      points      <= pointsNext;
    end
  end

endmodule

// File: tb/tb_fruit_drop_controller.sv
// Self-checking bench for fruit_drop_controller.
// Table vectors plus hand sequences for fall, pop, respawn, reset.
module tb_fruit_drop_controller;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic startOfFrame = 1'b0;
  logic playerHitFruit = 1'b0;
  logic fruitHitEnemy = 1'b0;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  int fruitChoice;
  logic drawFruit;
  logic scorePulse;
  logic [7:0] points;

  int nCmp = 0;
  int nFail = 0;

  typedef struct {
    logic sof;
    logic phf;
    logic fhe;
    int   y;
    logic draw;
    int   choice;
    logic score;
    int   pts;
  } vec_t;

  vec_t expQ[$];
  vec_t tbl[18];

  fruit_drop_controller dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .playerHitFruit(playerHitFruit),
    .fruitHitEnemy(fruitHitEnemy),
    .topLeftX(topLeftX),
    .topLeftY(topLeftY),
    .fruitChoice(fruitChoice),
    .drawFruit(drawFruit),
    .scorePulse(scorePulse),
    .points(points)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input vec_t e);
    check("topLeftX", int'(topLeftX), 200);
    check("topLeftY", int'(topLeftY), e.y);
    check("drawFruit", int'(drawFruit), int'(e.draw));
    check("fruitChoice", fruitChoice, e.choice);
    check("scorePulse", int'(scorePulse), int'(e.score));
    if (e.score) check("points", int'(points), e.pts);
  endtask

  task automatic applyVec(input vec_t v);
    vec_t e;
    @(negedge clk);
    startOfFrame = v.sof;
    playerHitFruit = v.phf;
    fruitHitEnemy = v.fhe;
    expQ.push_back(v);
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    playerHitFruit = 1'b0;
    fruitHitEnemy = 1'b0;
    if (expQ.size() == 0) begin
      nCmp++;
      nFail++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = expQ.pop_front();
      checkAll(e);
    end
  endtask

  task automatic step(input logic sof, input logic phf,
                      input logic fhe, input int y,
                      input logic draw, input int choice,
                      input logic score, input int pts);
    vec_t v;
    v.sof = sof; v.phf = phf; v.fhe = fhe;
    v.y = y; v.draw = draw; v.choice = choice;
    v.score = score; v.pts = pts;
    applyVec(v);
  endtask

  // Frames firstK..lastK of a fall from home; floor reached at 88.
  task automatic fallFrames(input int firstK, input int lastK,
                            input int choice);
    for (int k = firstK; k <= lastK; k++) begin
      int y;
      y = 64 + 4 * k;
      if (y > 416) y = 416;
      step(1, 0, 0, y, (y < 416), choice, 0, 0);
    end
  endtask

  // 30 blinking frames after a hit; last one lands in GONE.
  task automatic popFrames(input int y, input int choice);
    for (int n = 1; n <= 29; n++)
      step(1, 0, 0, y, ((n / 4) % 2) == 0, choice, 0, 0);
    step(1, 0, 0, y, 0, choice, 0, 0);
  endtask

  // 120 hidden frames, then back home with the next fruit.
  task automatic goneFrames(input int y, input int choice,
                            input int nextChoice);
    for (int j = 1; j <= 119; j++)
      step(1, 0, 0, y, 0, choice, 0, 0);
    step(1, 0, 0, 64, 1, nextChoice, 0, 0);
  endtask

  initial begin
    tbl = '{
      '{1, 0, 0, 64, 1, 0, 0, 0},
      '{1, 0, 0, 64, 1, 0, 0, 0},
      '{1, 0, 0, 64, 1, 0, 0, 0},
      '{1, 0, 0, 64, 1, 0, 0, 0},
      '{1, 0, 0, 64, 1, 0, 0, 0},
      '{0, 0, 1, 64, 1, 0, 0, 0},
      '{1, 1, 0, 64, 1, 0, 0, 0},
      '{1, 0, 0, 68, 1, 0, 0, 0},
      '{1, 0, 0, 72, 1, 0, 0, 0},
      '{1, 0, 0, 76, 1, 0, 0, 0},
      '{1, 0, 0, 80, 1, 0, 0, 0},
      '{1, 0, 0, 84, 1, 0, 0, 0},
      '{1, 0, 0, 88, 1, 0, 0, 0},
      '{1, 0, 0, 92, 1, 0, 0, 0},
      '{1, 0, 0, 96, 1, 0, 0, 0},
      '{1, 0, 0, 100, 1, 0, 0, 0},
      '{1, 0, 0, 104, 1, 0, 0, 0},
      '{0, 1, 0, 104, 1, 0, 0, 0}
    };

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst topLeftY", int'(topLeftY), 64);
    check("rst drawFruit", int'(drawFruit), 1);
    check("rst fruitChoice", fruitChoice, 0);
    check("rst scorePulse", int'(scorePulse), 0);
    check("rst points", int'(points), 0);
    resetN = 1'b0;

    // Idle hang, ignored enemy hit, drop, 10 steps, ignored player hit.
    for (int i = 0; i < 18; i++) applyVec(tbl[i]);

    // Continue to the floor at frame 88, then respawn as fruit 1.
    fallFrames(11, 88, 0);
    goneFrames(416, 0, 1);

    // Fruit 1: fall to 100, hit with a coincident frame tick.
    step(0, 1, 0, 64, 1, 1, 0, 0);
    fallFrames(1, 9, 1);
    step(1, 0, 1, 100, 1, 1, 1, 20);
    step(0, 0, 0, 100, 1, 1, 0, 0);
    popFrames(100, 1);
    goneFrames(100, 1, 2);

    // Fruit 2: hit on the same tick that would reach the floor.
    step(0, 1, 0, 64, 1, 2, 0, 0);
    fallFrames(1, 87, 2);
    step(1, 0, 1, 412, 1, 2, 1, 30);
    popFrames(412, 2);
    goneFrames(412, 2, 0);

    // Fruit 0 again: floor, respawn to fruit 1.
    step(1, 1, 0, 64, 1, 0, 0, 0);
    fallFrames(1, 88, 0);
    goneFrames(416, 0, 1);

    // Reset mid-POP while scorePulse is high.
    step(0, 1, 0, 64, 1, 1, 0, 0);
    fallFrames(1, 2, 1);
    step(0, 0, 1, 72, 1, 1, 1, 20);
    #2;
    resetN = 1'b1;
    #1;
    check("async topLeftY", int'(topLeftY), 64);
    check("async drawFruit", int'(drawFruit), 1);
    check("async fruitChoice", fruitChoice, 0);
    check("async scorePulse", int'(scorePulse), 0);
    check("async points", int'(points), 0);
    @(negedge clk);
    resetN = 1'b0;
    step(1, 0, 0, 64, 1, 0, 0, 0);

    if (expQ.size() != 0) begin
      nCmp++;
      nFail++;
      $display("FAIL scoreboard: %0d entries left", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
